// File: rtl/irq_prio_ctrl_pkg.sv
// Shared constants and FSM state encoding for the interrupt priority controller.
package irq_pkg;
  localparam int N_REQ = 16;
  localparam int ID_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;
endpackage

// File: rtl/irq_prio_ctrl_prio_enc.sv
// 16-to-4 priority encoder; bit 15 has the highest priority.
module prio_enc_n
  import irq_pkg::*;
(
  input  logic [15:0] cand,
  output logic [3:0]  enc_id,
  output logic        any
);

  always_comb begin
    enc_id = '0;
    // Ascending scan so the highest set bit is the last to write.
    for (int i = 0; i < N_REQ; i++) begin
      if (cand[i]) enc_id = ID_W'(i);
    end
    any = |cand;
  end

endmodule

// File: rtl/irq_prio_ctrl.sv
// Interrupt front-end: captures requests into pending, issues the highest
// enabled one over a valid/ack handshake and blocks until end-of-interrupt.
module irq_prio_ctrl
  import irq_pkg::*;
#(
  parameter int EDGE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req,
  input  logic [15:0] mask,
  input  logic        irq_ack,
  input  logic        eoi,
  output logic        irq_valid,
  output logic [3:0]  irq_id,
  output logic        busy,
  output logic [15:0] pending
);

  state_e      state_q, state_d;
  logic [15:0] req_prev_q;
  logic [15:0] pending_q, pending_d;
  logic        irq_valid_q, irq_valid_d;
  logic [3:0]  irq_id_q, irq_id_d;
  logic        busy_q, busy_d;
  logic [15:0] clr;
  logic [15:0] rise;
  logic [3:0]  enc_id;
  logic        any;

  prio_enc_n u_enc (
    .cand   (pending_q & mask),
    .enc_id (enc_id),
    .any    (any)
  );

  always_comb begin
    state_d     = state_q;
    irq_valid_d = irq_valid_q;
    irq_id_d    = irq_id_q;
    busy_d      = busy_q;
    clr         = '0;
    case (state_q)
      ST_IDLE: begin
        if (any) begin
          irq_id_d    = enc_id;
          irq_valid_d = 1'b1;
          state_d     = ST_REQ;
        end
      end
      ST_REQ: begin
        // irq_id is frozen here: later arrivals or mask changes do not preempt.
        if (irq_ack) begin
          clr[irq_id_q] = 1'b1;
          irq_valid_d   = 1'b0;
          busy_d        = 1'b1;
          state_d       = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        if (eoi) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        irq_valid_d = 1'b0;
        busy_d      = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase

    // A new rising edge on the bit being cleared wins over the clear.
    rise = req & ~req_prev_q;
    if (EDGE != 0) pending_d = (pending_q & ~clr) | rise;
    else           pending_d = req & ~clr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      req_prev_q  <= '0;
      pending_q   <= '0;
      irq_valid_q <= 1'b0;
      irq_id_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_prev_q  <= req;
      pending_q   <= pending_d;
      irq_valid_q <= irq_valid_d;
      irq_id_q    <= irq_id_d;
      busy_q      <= busy_d;
    end
  end

  assign irq_valid = irq_valid_q;
  assign irq_id    = irq_id_q;
  assign busy      = busy_q;
  assign pending   = pending_q;

endmodule

// File: tb/tb_irq_prio_ctrl.sv
// Directed bench for irq_prio_ctrl: vector table plus hand-written corner sequences.
module tb_irq_prio_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] req;
  logic [15:0] mask;
  logic        irq_ack;
  logic        eoi;
  logic        irq_valid;
  logic [3:0]  irq_id;
  logic        busy;
  logic [15:0] pending;

  int errors = 0;
  int checks = 0;

  irq_prio_ctrl #(.EDGE(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .mask      (mask),
    .irq_ack   (irq_ack),
    .eoi       (eoi),
    .irq_valid (irq_valid),
    .irq_id    (irq_id),
    .busy      (busy),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] req;
    logic [15:0] mask;
    logic        ack;
    logic        eoi;
    logic        valid;
    logic [3:0]  id;
    logic        busy;
    logic [15:0] pend;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic v, input logic [3:0] id,
                           input logic b, input logic [15:0] p);
    check({tag, " irq_valid"}, {15'd0, irq_valid}, {15'd0, v});
    check({tag, " irq_id"},    {12'd0, irq_id},    {12'd0, id});
    check({tag, " busy"},      {15'd0, busy},      {15'd0, b});
    check({tag, " pending"},   pending,            p);
  endtask

  // Drive inputs away from the edge, then sample 1 time unit after the edge.
  task automatic step(input logic [15:0] r, input logic [15:0] m, input logic a, input logic e);
    req = r; mask = m; irq_ack = a; eoi = e;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //                 req       mask      ack   eoi   valid id     busy  pending
    vecs[0]  = '{16'h0020, 16'hFFFF, 1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 16'h0020};
    vecs[1]  = '{16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b1, 4'd5,  1'b0, 16'h0020};
    vecs[2]  = '{16'h0000, 16'hFFFF, 1'b1, 1'b0, 1'b0, 4'd5,  1'b1, 16'h0000};
    vecs[3]  = '{16'h0000, 16'hFFFF, 1'b0, 1'b1, 1'b0, 4'd5,  1'b0, 16'h0000};
    vecs[4]  = '{16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b0, 4'd5,  1'b0, 16'h0000};
    vecs[5]  = '{16'h1008, 16'hFFFF, 1'b0, 1'b0, 1'b0, 4'd5,  1'b0, 16'h1008};
    vecs[6]  = '{16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b1, 4'd12, 1'b0, 16'h1008};
    vecs[7]  = '{16'h0000, 16'hFFFF, 1'b1, 1'b0, 1'b0, 4'd12, 1'b1, 16'h0008};
    vecs[8]  = '{16'h0000, 16'hFFFF, 1'b0, 1'b1, 1'b0, 4'd12, 1'b0, 16'h0008};
    vecs[9]  = '{16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b1, 4'd3,  1'b0, 16'h0008};
    vecs[10] = '{16'h0000, 16'hFFFF, 1'b1, 1'b0, 1'b0, 4'd3,  1'b1, 16'h0000};
    vecs[11] = '{16'h0000, 16'hFFFF, 1'b0, 1'b1, 1'b0, 4'd3,  1'b0, 16'h0000};
    vecs[12] = '{16'h0000, 16'hFFFF, 1'b1, 1'b0, 1'b0, 4'd3,  1'b0, 16'h0000};
    vecs[13] = '{16'h0000, 16'hFFFF, 1'b0, 1'b1, 1'b0, 4'd3,  1'b0, 16'h0000};

    rst = 1'b1; req = '0; mask = 16'hFFFF; irq_ack = 1'b0; eoi = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 check_all("reset", 1'b0, 4'd0, 1'b0, 16'h0000);

    for (int i = 0; i < 14; i++) begin
      step(vecs[i].req, vecs[i].mask, vecs[i].ack, vecs[i].eoi);
      check_all($sformatf("vec%0d", i), vecs[i].valid, vecs[i].id, vecs[i].busy, vecs[i].pend);
    end

    // Masked request waits, then issues once enabled.
    step(16'h0080, 16'hFF7F, 1'b0, 1'b0);
    check("mask pend", pending, 16'h0080);
    for (int i = 0; i < 10; i++) begin
      step(16'h0000, 16'hFF7F, 1'b0, 1'b0);
      check($sformatf("mask hold%0d valid", i), {15'd0, irq_valid}, 16'h0000);
    end
    step(16'h0000, 16'hFFFF, 1'b0, 1'b0);
    step(16'h0000, 16'hFFFF, 1'b0, 1'b0);
    check_all("unmask", 1'b1, 4'd7, 1'b0, 16'h0080);
    step(16'h0000, 16'hFFFF, 1'b1, 1'b0);
    step(16'h0000, 16'hFFFF, 1'b0, 1'b1);
    check_all("unmask done", 1'b0, 4'd7, 1'b0, 16'h0000);

    // No preemption; SERVICE blocks issue; ack+eoi together only acks.
    step(16'h0010, 16'hFFFF, 1'b0, 1'b0);
    step(16'h0000, 16'hFFFF, 1'b0, 1'b0);
    check_all("pre id4", 1'b1, 4'd4, 1'b0, 16'h0010);
    step(16'h8000, 16'hFFFF, 1'b0, 1'b0);
    check_all("pre hold", 1'b1, 4'd4, 1'b0, 16'h8010);
    step(16'h0000, 16'hFFFF, 1'b1, 1'b1);
    check_all("pre ack", 1'b0, 4'd4, 1'b1, 16'h8000);
    step(16'h0000, 16'hFFFF, 1'b0, 1'b0);
    step(16'h0000, 16'hFFFF, 1'b0, 1'b0);
    check_all("svc block", 1'b0, 4'd4, 1'b1, 16'h8000);
    step(16'h0000, 16'hFFFF, 1'b0, 1'b1);
    check_all("svc eoi", 1'b0, 4'd4, 1'b0, 16'h8000);
    step(16'h0000, 16'hFFFF, 1'b0, 1'b0);
    check_all("issue 15", 1'b1, 4'd15, 1'b0, 16'h8000);
    step(16'h0000, 16'hFFFF, 1'b1, 1'b0);
    step(16'h0000, 16'hFFFF, 1'b0, 1'b1);

    // Re-rise on the ack edge: set beats clear.
    step(16'h0200, 16'hFFFF, 1'b0, 1'b0);
    step(16'h0000, 16'hFFFF, 1'b0, 1'b0);
    check_all("id9", 1'b1, 4'd9, 1'b0, 16'h0200);
    step(16'h0200, 16'hFFFF, 1'b1, 1'b0);
    check_all("rerise ack", 1'b0, 4'd9, 1'b1, 16'h0200);
    step(16'h0000, 16'hFFFF, 1'b0, 1'b1);
    step(16'h0000, 16'hFFFF, 1'b0, 1'b0);
    check_all("reissue 9", 1'b1, 4'd9, 1'b0, 16'h0200);
    step(16'h0000, 16'hFFFF, 1'b1, 1'b0);
    step(16'h0000, 16'hFFFF, 1'b0, 1'b1);

    // Asynchronous reset in SERVICE, req[2] held through release.
    step(16'h0001, 16'hFFFF, 1'b0, 1'b0);
    step(16'h0000, 16'hFFFF, 1'b0, 1'b0);
    step(16'h0002, 16'hFFFF, 1'b1, 1'b0);
    check_all("pre rst svc", 1'b0, 4'd0, 1'b1, 16'h0002);
    #3 rst = 1'b1; req = 16'h0004; irq_ack = 1'b0;
    #1 check_all("async rst", 1'b0, 4'd0, 1'b0, 16'h0000);
    @(posedge clk);
    #5 rst = 1'b0;
    step(16'h0004, 16'hFFFF, 1'b0, 1'b0);
    check_all("rst edge", 1'b0, 4'd0, 1'b0, 16'h0004);
    step(16'h0004, 16'hFFFF, 1'b0, 1'b0);
    check_all("rst issue 2", 1'b1, 4'd2, 1'b0, 16'h0004);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
